store_buffer: RTL and testbench
===============================

Name: store_buffer

Overview:
- Small FIFO write buffer between the MEM-stage control and `dataMemory`. It sits directly upstream of the memory and owns its Address/WriteData/MemWrite/MemRead inputs.
- Stores from the pipeline are queued and drained to memory one per cycle, so the pipeline does not wait on the memory write.
- Loads check the buffer first: the youngest matching queued store is forwarded; on a miss the load goes to memory, and the load has priority over draining.

Parameters:
DEPTH, 4, number of queued stores (power of 2, at least 2)
ADDR_W, 32, address width passed unchanged to memory
DATA_W, 32, store/load data width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
st_valid  input  1  store request this cycle
st_addr  input  ADDR_W  store address
st_data  input  DATA_W  store data
st_ready  output  1  buffer can accept a store (not full)
ld_valid  input  1  load request this cycle
ld_addr  input  ADDR_W  load address
ld_data  output  DATA_W  load result, valid in the same cycle as ld_valid
ld_hit  output  1  load was served from the buffer
mem_addr  output  ADDR_W  to dataMemory Address
mem_wdata  output  DATA_W  to dataMemory WriteData
mem_write  output  1  to dataMemory MemWrite
mem_read  output  1  to dataMemory MemRead
mem_rdata  input  DATA_W  from dataMemory ReadData
count  output  log2(DEPTH)+1  number of occupied entries
empty  output  1  count==0

Behaviour:
- Storage: circular array of {addr, data} entries with wr_ptr, rd_ptr and count, all registered. Pointers wrap modulo DEPTH.
- Reset (synchronous, reset==1 at the clk edge): wr_ptr=rd_ptr=count=0.
  - All pending entries are discarded, including a reset that arrives mid-drain; entry contents are don't-care.
  - During and immediately after reset: st_ready=1, empty=1, count=0, mem_write=0.
  - reset has priority over st_valid and ld_valid in the same cycle.
- st_ready = (count != DEPTH), purely from registered state. No push-through when full.
- Push: st_valid && st_ready at the clk edge writes the entry at wr_ptr, then wr_ptr++.
  - st_valid while full is ignored; the entry is not written and the count is unchanged. The upstream stage must stall.
- Load lookup (combinational):
  - Compare ld_addr against every occupied entry, full ADDR_W equality.
  - ld_hit = ld_valid && any match. On a hit, ld_data = data of the youngest matching entry, i.e. the one closest to wr_ptr-1.
  - The store being pushed in the same cycle is not visible to the load; the load sees older state.
- Memory port arbitration (combinational each cycle):
  - Load miss (ld_valid && !ld_hit): mem_read=1, mem_write=0, mem_addr=ld_addr, ld_data=mem_rdata. Drain is held off this cycle.
  - Otherwise, if !empty: mem_write=1, mem_read=0, mem_addr/mem_wdata = entry at rd_ptr. rd_ptr++ at the clk edge.
  - Otherwise: mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0.
  - mem_write and mem_read are never both 1.
- Simultaneous push and drain: count unchanged; both pointers advance.
- Latency: a store accepted at edge N is driven to memory no earlier than the cycle after edge N. With no competing load misses, it reaches memory within count cycles.
- Ordering: drains go strictly in FIFO order, so repeated stores to one address reach memory in program order.
- ld_data is 0 when ld_valid==0.

Test Plan:
- Reset then idle -> st_ready=1, empty=1, count=0, mem_write=0, mem_read=0 for 5 cycles.
- Single store: push addr 4 / data 0xDEADBEEF -> next cycle mem_write=1, mem_addr=4, mem_wdata=0xDEADBEEF; the cycle after, empty=1.
- Fill: 4 back-to-back stores while loads are forced to miss (addr 0, so drain is blocked) -> st_ready=0 and count=4. A 5th store is ignored. Once loads stop, entries drain in order and count goes 4,3,2,1,0.
- Forwarding: queue addr 8 = 0x11, then addr 8 = 0x22, then load addr 8 -> ld_hit=1, ld_data=0x22, mem_read=0. Memory later receives 0x11, then 0x22.
- Load miss with a pending drain: one entry queued, load addr 12 with mem_rdata=0x55 -> mem_read=1, ld_data=0x55, mem_write=0, count stays 1. The drain happens the next cycle.
- Reset mid-operation: 3 entries queued, reset asserted for 1 cycle -> count=0, no further mem_write; a later load of one of those addresses misses.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer: FIFO write buffer in front of dataMemory with youngest-match load forwarding
module store_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       st_valid,
   input  logic [ADDR_W-1:0]          st_addr,
   input  logic [DATA_W-1:0]          st_data,
   output logic                       st_ready,
   input  logic                       ld_valid,
   input  logic [ADDR_W-1:0]          ld_addr,
   output logic [DATA_W-1:0]          ld_data,
   output logic                       ld_hit,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   output logic                       mem_write,
   output logic                       mem_read,
   input  logic [DATA_W-1:0]          mem_rdata,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       empty
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
   logic [ADDR_W-1:0] entAddr [DEPTH];
   logic [DATA_W-1:0] entData [DEPTH];
   logic [PW-1:0] wrPtr, rdPtr, idx;
   logic match, ldMiss, drain, push;
   logic [DATA_W-1:0] matchData;
   // Walk oldest to youngest so the last hit is the youngest matching store
   always_comb begin
      match = 1'b0;
      matchData = '0;
      idx = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rdPtr + PW'(k);
         if ((PW+1)'(k) < count && entAddr[idx] == ld_addr) begin
            match = 1'b1;
            matchData = entData[idx];
         end
      end
   end
   assign empty     = count == '0;
   assign st_ready  = count != FULL;
   assign push      = st_valid && st_ready;
   assign ld_hit    = ld_valid && match;
   assign ldMiss    = ld_valid && !match;
   assign drain     = !ldMiss && !empty;
   assign mem_read  = ldMiss;
   assign mem_write = drain;
   assign mem_addr  = ldMiss ? ld_addr : drain ? entAddr[rdPtr] : '0;
   assign mem_wdata = drain ? entData[rdPtr] : '0;
   assign ld_data   = !ld_valid ? '0 : match ? matchData : mem_rdata;
   always_ff @(posedge clk) begin
      if (push) begin
         entAddr[wrPtr] <= st_addr;
         entData[wrPtr] <= st_data;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         wrPtr <= push ? wrPtr + PW'(1) : wrPtr;
         rdPtr <= drain ? rdPtr + PW'(1) : rdPtr;
         count <= (push && !drain) ? count + (PW+1)'(1) :
                  (!push && drain) ? count - (PW+1)'(1) : count;
      end
   end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed and random stimulus against a queue-based model of the store buffer
module tb_store_buffer;
   localparam int DEPTH = 4;
   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } ent_t;
   logic clk = 1'b0;
   logic reset, st_valid, st_ready, ld_valid, ld_hit, mem_write, mem_read, empty;
   logic [31:0] st_addr, st_data, ld_addr, ld_data, mem_addr, mem_wdata, mem_rdata;
   logic [2:0] count;
   int checks = 0;
   int failures = 0;
   ent_t q[$];
   always #5 clk = ~clk;
   store_buffer #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_hit(ld_hit),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
      .mem_rdata(mem_rdata), .count(count), .empty(empty)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic step(input logic r, input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la, input logic [31:0] rd);
      logic hit, miss, drn;
      logic [31:0] hd;
      @(negedge clk);
      reset = r; st_valid = sv; st_addr = sa; st_data = sd;
      ld_valid = lv; ld_addr = la; mem_rdata = rd;
      #1;
      hit = 1'b0;
      hd = '0;
      for (int i = q.size() - 1; i >= 0; i--)
         if (q[i].a == la) begin
            hit = 1'b1;
            hd = q[i].d;
            break;
         end
      miss = lv && !hit;
      drn = !miss && q.size() > 0;
      chk("st_ready", st_ready, q.size() != DEPTH);
      chk("empty", empty, q.size() == 0);
      chk("count", count, q.size());
      chk("ld_hit", ld_hit, lv && hit);
      chk("ld_data", ld_data, !lv ? 32'h0 : hit ? hd : rd);
      chk("mem_read", mem_read, miss);
      chk("mem_write", mem_write, drn);
      chk("mem_addr", mem_addr, miss ? la : drn ? q[0].a : 32'h0);
      chk("mem_wdata", mem_wdata, drn ? q[0].d : 32'h0);
      if (r) q.delete();
      else begin
         logic full;
         full = q.size() == DEPTH;
         if (drn) void'(q.pop_front());
         if (sv && !full) q.push_back('{a: sa, d: sd});
      end
   endtask
   initial begin
      reset = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0;
      ld_valid = 1'b0; ld_addr = '0; mem_rdata = '0;
      repeat (2) @(posedge clk);
      step(1, 0, 0, 0, 0, 0, 0);
      repeat (5) step(0, 0, 0, 0, 0, 0, $urandom);
      // single store, then drain
      step(0, 1, 4, 32'hDEADBEEF, 0, 0, 0);
      repeat (2) step(0, 0, 0, 0, 0, 0, 0);
      // fill while load misses block the drain
      for (int i = 0; i < 4; i++) step(0, 1, 16 + 4 * i, $urandom, 1, 0, $urandom);
      step(0, 1, 32, 32'hBAD, 1, 0, $urandom);
      @(posedge clk);
      #1;
      chk("fill_count", count, 4);
      chk("fill_ready", st_ready, 0);
      repeat (5) step(0, 0, 0, 0, 0, 0, 0);
      // forwarding of the youngest store to one address
      step(0, 1, 8, 32'h11, 1, 0, 0);
      step(0, 1, 8, 32'h22, 1, 0, 0);
      step(0, 0, 0, 0, 1, 8, 32'h99);
      repeat (3) step(0, 0, 0, 0, 0, 0, 0);
      // load miss while a drain is pending
      step(0, 1, 40, 32'hA5A5, 0, 0, 0);
      step(0, 0, 0, 0, 1, 12, 32'h55);
      repeat (2) step(0, 0, 0, 0, 0, 0, 0);
      // reset mid-operation discards queued stores
      for (int i = 0; i < 3; i++) step(0, 1, 44 + 4 * i, $urandom, 1, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 48, 32'h77);
      repeat (2) step(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 49) == 0, $urandom_range(0, 1), 4 * $urandom_range(0, 3), $urandom,
              $urandom_range(0, 4) < 2, 4 * $urandom_range(0, 3), $urandom);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
